// File: rtl/wishbone_sram_slave_pkg.sv
// Shared types and constants for the Wishbone-to-asynchronous-SRAM responder.
package wishbone_sram_slave_pkg;

    localparam int WB_SEL_BASE = 0;
    localparam int WB_SEL_EXT  = 1;

    localparam int SRAM_ADDR_W = 20;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [31:0]            reg_bus_t;

    localparam reg_bus_t   ZERO_WORD = 32'h0000_0000;
    localparam logic [3:0] BE_NONE   = 4'hF;
    localparam logic [3:0] BE_ALL    = 4'h0;

    typedef enum logic [2:0] {
        SRAM_IDLE,
        SRAM_READ,
        SRAM_WR_SETUP,
        SRAM_WR_PULSE,
        SRAM_WR_HOLD
    } sram_state_e;

endpackage

// File: rtl/wishbone_sram_slave.sv
// Wishbone responder running multi-cycle asynchronous SRAM accesses on two banks.
// Every output is a flop; output next-values are decoded from the next state.
module wishbone_sram_slave
    import wishbone_sram_slave_pkg::*;
#(
    parameter int READ_WAIT = 2,
    parameter int WE_PULSE  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_select_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i,
    output logic        sram_data_oe,
    output logic        base_ce_n,
    output logic        ext_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    localparam int MAX_WAIT = (READ_WAIT > WE_PULSE) ? READ_WAIT : WE_PULSE;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WE_PULSE - 1);

    sram_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sram_addr_t       addr_q, addr_d;
    reg_bus_t         wdata_q, wdata_d;
    reg_bus_t         rdata_q, rdata_d;
    logic             ext_q, ext_d;
    logic             ack_q, ack_d;
    logic             base_ce_n_q, base_ce_n_d;
    logic             ext_ce_n_q, ext_ce_n_d;
    logic             oe_n_q, oe_n_d;
    logic             we_n_q, we_n_d;
    logic             data_oe_q, data_oe_d;
    logic [3:0]       be_n_q, be_n_d;
    logic             hit;
    logic             busy_d;

    // Address/select bits owned by other responders or below word granularity.
    logic unused_bits;
    assign unused_bits = ^{wb_addr_i[31:22], wb_addr_i[1:0], wb_select_i[15:2]};

    assign hit = wb_select_i[WB_SEL_BASE] | wb_select_i[WB_SEL_EXT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ext_d   = ext_q;
        case (state_q)
            SRAM_IDLE: begin
                if (hit) begin
                    addr_d  = wb_addr_i[21:2];
                    wdata_d = wb_data_i;
                    ext_d   = ~wb_select_i[WB_SEL_BASE];
                    cnt_d   = '0;
                    state_d = wb_we_i ? SRAM_WR_SETUP : SRAM_READ;
                end
            end
            SRAM_READ: begin
                if (cnt_q == READ_LAST) begin
                    rdata_d = sram_data_i;
                    cnt_d   = '0;
                    state_d = SRAM_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SRAM_WR_SETUP: begin
                cnt_d   = '0;
                state_d = SRAM_WR_PULSE;
            end
            SRAM_WR_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = SRAM_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SRAM_WR_HOLD: begin
                state_d = SRAM_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = SRAM_IDLE;
            end
        endcase

        busy_d      = (state_d != SRAM_IDLE);
        ack_d       = ~busy_d;
        base_ce_n_d = ~(busy_d & ~ext_d);
        ext_ce_n_d  = ~(busy_d & ext_d);
        oe_n_d      = (state_d != SRAM_READ);
        we_n_d      = (state_d != SRAM_WR_PULSE);
        data_oe_d   = (state_d == SRAM_WR_SETUP) || (state_d == SRAM_WR_PULSE) ||
                      (state_d == SRAM_WR_HOLD);
        be_n_d      = busy_d ? BE_ALL : BE_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SRAM_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= ZERO_WORD;
            rdata_q     <= ZERO_WORD;
            ext_q       <= 1'b0;
            ack_q       <= 1'b1;
            base_ce_n_q <= 1'b1;
            ext_ce_n_q  <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            be_n_q      <= BE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ext_q       <= ext_d;
            ack_q       <= ack_d;
            base_ce_n_q <= base_ce_n_d;
            ext_ce_n_q  <= ext_ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            data_oe_q   <= data_oe_d;
            be_n_q      <= be_n_d;
        end
    end

    assign wb_data_o    = rdata_q;
    assign wb_ack_o     = ack_q;
    assign sram_addr_o  = addr_q;
    assign sram_data_o  = wdata_q;
    assign sram_data_oe = data_oe_q;
    assign base_ce_n    = base_ce_n_q;
    assign ext_ce_n     = ext_ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_wishbone_sram_slave.sv
// Directed bench: a timeline-level bus model checked every cycle, an SRAM pin model,
// and literal per-transaction expectations.
module tb_wishbone_sram_slave;

    localparam int RW = 2;
    localparam int WP = 2;

    logic        clk;
    logic        rst;
    logic [31:0] wb_addr;
    logic [31:0] wb_data_w;
    logic        wb_we;
    logic [15:0] wb_sel;
    logic [31:0] wb_data_r;
    logic        wb_ack;
    logic [19:0] sram_addr;
    logic [31:0] sram_dout;
    logic [31:0] sram_din;
    logic        sram_doe;
    logic        base_ce_n;
    logic        ext_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int n_cmp = 0;
    int n_err = 0;

    wishbone_sram_slave #(.READ_WAIT(RW), .WE_PULSE(WP)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data_w),
        .wb_we_i      (wb_we),
        .wb_select_i  (wb_sel),
        .wb_data_o    (wb_data_r),
        .wb_ack_o     (wb_ack),
        .sram_addr_o  (sram_addr),
        .sram_data_o  (sram_dout),
        .sram_data_i  (sram_din),
        .sram_data_oe (sram_doe),
        .base_ce_n    (base_ce_n),
        .ext_ce_n     (ext_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_be_n    (sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM pin model: two banks of 256 words, written while we_n is low.
    logic [31:0] base_mem [256];
    logic [31:0] ext_mem  [256];

    assign sram_din = (!sram_oe_n && !base_ce_n) ? base_mem[sram_addr[7:0]] :
                      (!sram_oe_n && !ext_ce_n)  ? ext_mem[sram_addr[7:0]]  : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!rst) base_mem[8'h40] <= 32'hDEAD_BEEF;
        if (!sram_we_n && sram_doe) begin
            if (!base_ce_n)     base_mem[sram_addr[7:0]] <= sram_dout;
            else if (!ext_ce_n) ext_mem[sram_addr[7:0]]  <= sram_dout;
        end
    end

    // Timeline model: m_k = cycle number within the current access (0 = idle).
    logic [31:0] ref_base [256];
    logic [31:0] ref_ext  [256];
    int          m_k = 0;
    logic        m_wr = 1'b0;
    logic        m_ext = 1'b0;
    logic [19:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_k      <= 0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
            m_valid  <= 1'b1;
            ref_base[8'h40] <= 32'hDEAD_BEEF;
        end else if (m_k == 0) begin
            if (wb_sel[0] | wb_sel[1]) begin
                m_k     <= 1;
                m_wr    <= wb_we;
                m_ext   <= ~wb_sel[0];
                m_addr  <= wb_addr[21:2];
                m_wdata <= wb_data_w;
            end
        end else if (m_k == (m_wr ? WP + 2 : RW)) begin
            m_k <= 0;
            if (m_wr) begin
                if (m_ext) ref_ext[m_addr[7:0]]  <= m_wdata;
                else       ref_base[m_addr[7:0]] <= m_wdata;
            end else begin
                m_rdata <= m_ext ? ref_ext[m_addr[7:0]] : ref_base[m_addr[7:0]];
            end
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            automatic logic busy = (m_k != 0);
            automatic logic rd   = busy && !m_wr;
            automatic logic wr   = busy && m_wr;
            automatic logic pls  = wr && (m_k >= 2) && (m_k <= WP + 1);
            check("m_ack",     {31'b0, wb_ack},    {31'b0, !busy});
            check("m_base_ce", {31'b0, base_ce_n}, {31'b0, !(busy && !m_ext)});
            check("m_ext_ce",  {31'b0, ext_ce_n},  {31'b0, !(busy && m_ext)});
            check("m_oe_n",    {31'b0, sram_oe_n}, {31'b0, !rd});
            check("m_we_n",    {31'b0, sram_we_n}, {31'b0, !pls});
            check("m_doe",     {31'b0, sram_doe},  {31'b0, wr});
            check("m_be_n",    {28'b0, sram_be_n}, busy ? 32'h0 : 32'hF);
            check("m_wb_data", wb_data_r, m_rdata);
            if (busy) check("m_addr", {12'b0, sram_addr}, {12'b0, m_addr});
            if (wr)   check("m_wdata", sram_dout, m_wdata);
        end
    end

    // Caller sits on a negedge; returns on the negedge where ack is back to 1.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] data,
                           input logic we, input logic [15:0] sel,
                           output int ack_lo, output int b_lo, output int e_lo,
                           output int oe_lo, output int we_lo, output int doe_hi,
                           output logic [19:0] first_addr);
        ack_lo = 0; b_lo = 0; e_lo = 0; oe_lo = 0; we_lo = 0; doe_hi = 0;
        first_addr = '1;
        wb_addr = addr; wb_data_w = data; wb_we = we; wb_sel = sel;
        @(posedge clk);
        #1;
        wb_sel = 16'h0004; wb_we = ~we; wb_addr = 32'hFFFF_FFFC; wb_data_w = ~data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_ack) break;
            if (ack_lo == 0) first_addr = sram_addr;
            ack_lo++;
            if (!base_ce_n) b_lo++;
            if (!ext_ce_n)  e_lo++;
            if (!sram_oe_n) oe_lo++;
            if (!sram_we_n) we_lo++;
            if (sram_doe)   doe_hi++;
        end
        check("ack_return", {31'b0, wb_ack}, 32'h1);
        $display("txn addr=%h we=%0b sel=%h: ack_low=%0d base=%0d ext=%0d oe=%0d we=%0d doe=%0d rdata=%h",
                 addr, we, sel, ack_lo, b_lo, e_lo, oe_lo, we_lo, doe_hi, wb_data_r);
    endtask

    int a, b, e, o, w, d;
    logic [19:0] fa;

    initial begin
        rst = 1'b0; wb_sel = 16'h0001; wb_addr = 32'h0000_0100; wb_data_w = '0; wb_we = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack",   {31'b0, wb_ack},    32'h1);
        check("rst_ce",    {30'b0, base_ce_n, ext_ce_n}, 32'h3);
        check("rst_oe_we", {30'b0, sram_oe_n, sram_we_n}, 32'h3);
        check("rst_be",    {28'b0, sram_be_n}, 32'hF);
        check("rst_addr",  {12'b0, sram_addr}, 32'h0);
        check("rst_dout",  sram_dout, 32'h0);
        check("rst_doe",   {31'b0, sram_doe}, 32'h0);
        check("rst_rdata", wb_data_r, 32'h0);
        $display("txn reset: ack=%0b ce=%0b%0b", wb_ack, base_ce_n, ext_ce_n);
        rst = 1'b1; wb_sel = 16'h0000;
        @(negedge clk);

        run_req(32'h0000_0100, 32'h0, 1'b0, 16'h0001, a, b, e, o, w, d, fa);
        check("rd_ack_low", a, 2); check("rd_base", b, 2); check("rd_oe", o, 2);
        check("rd_ext", e, 0); check("rd_addr", {12'b0, fa}, 32'h40);
        check("rd_data", wb_data_r, 32'hDEAD_BEEF);
        @(negedge clk);

        run_req(32'h0000_0008, 32'h1234_5678, 1'b1, 16'h0002, a, b, e, o, w, d, fa);
        check("wr_ack_low", a, 4); check("wr_we", w, 2); check("wr_ext", e, 4);
        check("wr_doe", d, 4); check("wr_base", b, 0); check("wr_oe", o, 0);
        check("wr_rdata_kept", wb_data_r, 32'hDEAD_BEEF);
        check("wr_mem", ext_mem[2], 32'h1234_5678);
        @(negedge clk);

        run_req(32'h0000_0008, 32'h0, 1'b0, 16'h0002, a, b, e, o, w, d, fa);
        check("rd_ext_data", wb_data_r, 32'h1234_5678); check("rd_ext_ce", e, 2);

        wb_sel = 16'h0004; wb_we = 1'b0; wb_addr = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("miss_ack", {31'b0, wb_ack}, 32'h1);
            check("miss_ce", {30'b0, base_ce_n, ext_ce_n}, 32'h3);
            check("miss_data", wb_data_r, 32'h1234_5678);
        end
        $display("txn miss sel=0004: ack=%0b rdata=%h", wb_ack, wb_data_r);

        run_req(32'h0000_0100, 32'h0, 1'b0, 16'h0003, a, b, e, o, w, d, fa);
        check("prio_base", b, 2); check("prio_ext", e, 0);
        check("prio_data", wb_data_r, 32'hDEAD_BEEF);
        @(negedge clk);

        run_req(32'h0000_0100, 32'h0, 1'b0, 16'h0001, a, b, e, o, w, d, fa);
        check("b2b_rd", wb_data_r, 32'hDEAD_BEEF);
        run_req(32'h0000_0104, 32'hCAFE_F00D, 1'b1, 16'h0001, a, b, e, o, w, d, fa);
        check("b2b_wr_ack_low", a, 4); check("b2b_wr_we", w, 2);
        check("b2b_addr", {12'b0, fa}, 32'h41);
        check("b2b_mem", base_mem[8'h41], 32'hCAFE_F00D);
        @(negedge clk);
        run_req(32'h0000_0104, 32'h0, 1'b0, 16'h0001, a, b, e, o, w, d, fa);
        check("b2b_readback", wb_data_r, 32'hCAFE_F00D);

        wb_addr = 32'h0000_0200; wb_data_w = 32'h55AA_55AA; wb_we = 1'b1; wb_sel = 16'h0001;
        @(posedge clk);
        #1 wb_sel = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        check("mid_we_low", {31'b0, sram_we_n}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_we_n", {31'b0, sram_we_n}, 32'h1);
        check("mid_ce", {31'b0, base_ce_n}, 32'h1);
        check("mid_doe", {31'b0, sram_doe}, 32'h0);
        check("mid_ack", {31'b0, wb_ack}, 32'h1);
        $display("txn reset mid-write: we_n=%0b ce=%0b ack=%0b", sram_we_n, base_ce_n, wb_ack);
        @(negedge clk);
        rst = 1'b1;
        run_req(32'h0000_0100, 32'h0, 1'b0, 16'h0001, a, b, e, o, w, d, fa);
        check("post_rst_ack_low", a, 2);
        check("post_rst_data", wb_data_r, 32'hDEAD_BEEF);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
